// File: rtl/ps2_pkg.sv
// Shared types and sizing helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_rx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line;
// level idles high and fall pulses for one cycle on a filtered 1->0 change.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = 16
) (
  input  logic main_clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = cnt_width(FILTER_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;

  // The level flips on the FILTER_CYCLES-th consecutive opposite sample.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level   <= 1'b1;
      fall    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      fall    <= 1'b0;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        level <= sync2_q;
        fall  <= level;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host deframer with FWFT byte FIFO and clock inhibit.
// Define PS2_RX_PARITY_CHECK_EN to drop bad-parity frames and count them.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 166667,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic          main_clk,
  input  logic          reset,
  input  logic          ps2_clock_in,
  input  logic          ps2_data_in,
  output logic          ps2_clock_pulldown,
  output logic          ps2_data_pulldown,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [7:0]    frame_error_count,
  output logic [7:0]    parity_error_count,
  output logic          overflow,
  input  logic          overflow_clear,
  output ps2_rx_state_t rx_state
);

  localparam int TW    = cnt_width(TIMEOUT_CYCLES);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  logic clk_filt, clk_fall, data_filt, data_fall_unused;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .main_clk (main_clk),
    .reset    (reset),
    .line_in  (ps2_clock_in),
    .level    (clk_filt),
    .fall     (clk_fall)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .main_clk (main_clk),
    .reset    (reset),
    .line_in  (ps2_data_in),
    .level    (data_filt),
    .fall     (data_fall_unused)
  );

  ps2_rx_state_t state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push_q, push_d;
  logic          frame_err_inc, parity_err_inc;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic          parity_q, parity_d;
`endif

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      timer_q   <= '0;
      push_q    <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      push_q    <= push_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    timer_d        = '0;
    push_d         = 1'b0;
    frame_err_inc  = 1'b0;
    parity_err_inc = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    parity_d       = parity_q;
`endif
    if (state_q != ST_IDLE && !clk_fall) timer_d = timer_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (clk_fall) begin
          if (!data_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
`ifdef PS2_RX_PARITY_CHECK_EN
          parity_d = data_filt;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          state_d = ST_IDLE;
          if (!data_filt) begin
            frame_err_inc = 1'b1;
          end else begin
`ifdef PS2_RX_PARITY_CHECK_EN
            if (^{shift_q, parity_q}) push_d = 1'b1;
            else parity_err_inc = 1'b1;
`else
            push_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled frame is abandoned; any partial byte is simply never pushed.
    if (state_q != ST_IDLE && !clk_fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d       = ST_IDLE;
      timer_d       = '0;
      frame_err_inc = 1'b1;
    end
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      frame_error_count  <= '0;
      parity_error_count <= '0;
    end else begin
      if (frame_err_inc && frame_error_count != 8'hFF)
        frame_error_count <= frame_error_count + 1'b1;
      if (parity_err_inc && parity_error_count != 8'hFF)
        parity_error_count <= parity_error_count + 1'b1;
    end
  end

  // Pop handshake: a byte leaves the FIFO on any cycle where rx_valid && rx_ready;
  // rx_data is only meaningful while rx_valid is high and reads 0 otherwise.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = rx_valid && rx_ready;
  assign push_ok = push_q && (!full || pop);

  always_ff @(posedge main_clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
      if (push_q && full && !pop) overflow <= 1'b1;
      else if (overflow_clear)    overflow <= 1'b0;
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr_q] : 8'h00;
  assign rx_state = state_q;

  assign ps2_clock_pulldown = !reset && (state_q == ST_IDLE) && clk_filt &&
                              (count_q >= CW'(DEPTH - 1));
  assign ps2_data_pulldown  = 1'b0;

endmodule
